// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler that shares one UART transmitter between NUM_REQ
// byte sources. A winning request has its byte latched, the transmitter is
// triggered with a one-cycle tx_en, and the arbiter then waits for tx_done.
// When tx_done arrives, the owning requester is told that its frame is
// finished. An optional idle gap can be forced between frames, and an
// optional watchdog abandons a frame whose tx_done never arrives.
//
// Ports:
//   PCLK        system clock
//   PRESET      synchronous active-high reset
//   req         per-requester request, held with stable data until req_ack
//   req_data    packed request bytes, requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ack     one-hot 1-cycle pulse: byte accepted (LAUNCH cycle)
//   req_done    one-hot 1-cycle pulse: that requester's frame finished
//   tx_en       1-cycle trigger to the transmitter
//   tx_data     byte to the transmitter, stable from tx_en until next grant
//   tx_busy     transmitter busy (only looked at in IDLE)
//   tx_done     transmitter done pulse (only looked at in WAIT_DONE)
//   grant_id    index of current / last granted requester
//   arb_busy    high in every state except IDLE
//   timeout_err 1-cycle pulse when the watchdog expires
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 200000
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         tx_en,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         arb_busy,
    output logic                         timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TO_W  = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    // Terminal counts; unused (held at zero) when the feature is disabled.
    localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT_CLKS > 0) ? TO_W'(TIMEOUT_CLKS - 1) : {TO_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : {GAP_W{1'b0}};
    // Pointer starts at the top index so requester 0 is scanned first.
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t               state_r,    state_s;
    logic [ID_W-1:0]      last_r,     last_s;
    logic [ID_W-1:0]      grant_r,    grant_s;
    logic [DATA_BITS-1:0] data_r,     data_s;
    logic [TO_W-1:0]      to_cnt_r,   to_cnt_s;
    logic [GAP_W-1:0]     gap_cnt_r,  gap_cnt_s;
    logic [NUM_REQ-1:0]   done_r,     done_s;
    logic                 terr_r,     terr_s;

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id == ID_W'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // First asserted request scanning last+1, last+2, ... modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last) + i) % NUM_REQ);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Byte of the requester with the given index.
    function automatic logic [DATA_BITS-1:0] byte_of(input logic [NUM_REQ*DATA_BITS-1:0] d,
                                                     input logic [ID_W-1:0]              id);
        logic [DATA_BITS-1:0] b;
        b = {DATA_BITS{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id == ID_W'(i)) begin
                b = d[i*DATA_BITS +: DATA_BITS];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // Next-state and next-datapath computation for the scheduler.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        grant_s   = grant_r;
        data_s    = data_r;
        to_cnt_s  = to_cnt_r;
        gap_cnt_s = gap_cnt_r;
        done_s    = {NUM_REQ{1'b0}};
        terr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((|req) && !tx_busy) begin
                    grant_s = rr_pick(req, last_r);
                    data_s  = byte_of(req_data, grant_s);
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                last_s   = grant_r;
                to_cnt_s = {TO_W{1'b0}};
                state_s  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // tx_done takes priority over a watchdog expiry in the same cycle.
                if (tx_done) begin
                    done_s    = id_onehot(grant_r);
                    gap_cnt_s = {GAP_W{1'b0}};
                    state_s   = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
                end else if ((TIMEOUT_CLKS > 0) && (to_cnt_r == TO_LAST)) begin
                    terr_s    = 1'b1;
                    gap_cnt_s = {GAP_W{1'b0}};
                    state_s   = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
                end else if ((TIMEOUT_CLKS > 0) && (to_cnt_r != TO_LAST)) begin
                    to_cnt_s = to_cnt_r + TO_W'(1'b1);
                end else begin
                    to_cnt_s = to_cnt_r;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            last_r    <= LAST_RST;
            grant_r   <= {ID_W{1'b0}};
            data_r    <= {DATA_BITS{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            done_r    <= {NUM_REQ{1'b0}};
            terr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            grant_r   <= grant_s;
            data_r    <= data_s;
            to_cnt_r  <= to_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            done_r    <= done_s;
            terr_r    <= terr_s;
        end
    end

    // Moore outputs decoded only from registered state.
    always_comb begin
        tx_en    = 1'b0;
        req_ack  = {NUM_REQ{1'b0}};
        arb_busy = 1'b0;
        if (state_r == ST_LAUNCH) begin
            tx_en   = 1'b1;
            req_ack = id_onehot(grant_r);
        end else begin
            tx_en   = 1'b0;
            req_ack = {NUM_REQ{1'b0}};
        end
        if (state_r != ST_IDLE) begin
            arb_busy = 1'b1;
        end else begin
            arb_busy = 1'b0;
        end
    end

    assign tx_data     = data_r;
    assign grant_id    = grant_r;
    assign req_done    = done_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Drives two arbiter instances (no gap, and a 3-cycle gap; both with a
// 50-cycle watchdog) one at a time from shared stimulus. A timestamp-based
// reference model predicts every output for every cycle: when the arbiter
// is free, which requester wins, when req_done / timeout_err fire and when
// the arbiter becomes idle again.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int TO    = 50;
    localparam int GAP_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            preset    = 1'b1;
    logic            sel       = 1'b0;
    logic [N-1:0]    req_v     = '0;
    logic [N*DW-1:0] data_v    = '0;
    logic            tx_busy_v = 1'b0;
    logic            tx_done_v = 1'b0;

    logic [N-1:0]  req_a, req_b;
    logic [N-1:0]  a_ack, a_done, b_ack, b_done, o_ack, o_done;
    logic          a_en, b_en, o_en, a_terr, b_terr, o_terr, a_busy, b_busy, o_busy;
    logic [1:0]    a_gid, b_gid, o_gid;
    logic [DW-1:0] a_data, b_data, o_data;

    assign req_a = sel ? {N{1'b0}} : req_v;
    assign req_b = sel ? req_v : {N{1'b0}};

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .GAP_CLKS(0), .TIMEOUT_CLKS(TO)) u_dut_a (
        .PCLK(clk), .PRESET(preset), .req(req_a), .req_data(data_v),
        .req_ack(a_ack), .req_done(a_done), .tx_en(a_en), .tx_data(a_data),
        .tx_busy(tx_busy_v), .tx_done(tx_done_v), .grant_id(a_gid),
        .arb_busy(a_busy), .timeout_err(a_terr));

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .GAP_CLKS(GAP_B), .TIMEOUT_CLKS(TO)) u_dut_b (
        .PCLK(clk), .PRESET(preset), .req(req_b), .req_data(data_v),
        .req_ack(b_ack), .req_done(b_done), .tx_en(b_en), .tx_data(b_data),
        .tx_busy(tx_busy_v), .tx_done(tx_done_v), .grant_id(b_gid),
        .arb_busy(b_busy), .timeout_err(b_terr));

    assign o_ack  = sel ? b_ack  : a_ack;
    assign o_done = sel ? b_done : a_done;
    assign o_en   = sel ? b_en   : a_en;
    assign o_terr = sel ? b_terr : a_terr;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_gid  = sel ? b_gid  : a_gid;
    assign o_data = sel ? b_data : a_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state (timestamps in cycle numbers).
    bit           frame_open;
    bit           armed;
    int           free_at;
    int           launch_at;
    int           owner;
    int           last;
    logic [N-1:0] e_ack, e_done;
    logic         e_en, e_terr, e_busy;
    logic [1:0]   e_gid;
    logic [DW-1:0] e_data;

    // Stimulus state: requesters and transmitter.
    logic [N-1:0]  want;
    logic [DW-1:0] bytes [N];
    bit            tx_active;
    int            tx_start, tx_len, busy_len;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_next(input int from, input logic [N-1:0] r);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (from + k) % N;
            if (r[c[1:0]]) return c;
        end
        return from;
    endfunction

    task automatic run_phase(input logic p_sel, input int ncyc, input int mode);
        logic [N-1:0] n_ack, n_done, one_v;
        logic         n_en, n_terr;
        bit           rst_now;
        int           gap, pick, r;
        one_v = {{(N-1){1'b0}}, 1'b1};
        gap   = p_sel ? GAP_B : 0;
        sel   = p_sel;
        armed = 1'b0;
        want  = '0;
        tx_active = 1'b0;
        e_ack = '0; e_en = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (armed) begin
                chk("req_ack",     32'(o_ack),  32'(e_ack));
                chk("req_done",    32'(o_done), 32'(e_done));
                chk("tx_en",       32'(o_en),   32'(e_en));
                chk("timeout_err", 32'(o_terr), 32'(e_terr));
                chk("arb_busy",    32'(o_busy), 32'(e_busy));
                chk("grant_id",    32'(o_gid),  32'(e_gid));
                chk("tx_data",     32'(o_data), 32'(e_data));
            end
            rst_now = (k < 2) || ((mode >= 2) && ($urandom_range(0, 599) == 0));
            preset  = rst_now;

            // Requesters drop after their ack, then maybe raise a new request.
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) want[i] = 1'b0;
                if (mode == 0) begin
                    if (k == 3 && i == 0) begin
                        want[0]  = 1'b1;
                        bytes[0] = 8'hA5;
                    end
                end else if (mode == 1) begin
                    if (!want[i]) begin
                        want[i]  = 1'b1;
                        bytes[i] = 8'(8'h10 + i);
                    end
                end else begin
                    if (!want[i] && $urandom_range(0, 5) == 0) begin
                        want[i]  = 1'b1;
                        bytes[i] = 8'($urandom);
                    end else if (want[i] && $urandom_range(0, 39) == 0) begin
                        want[i] = 1'b0;
                    end
                end
            end
            req_v = want;
            for (int i = 0; i < N; i++) data_v[i*DW +: DW] = bytes[i];

            // Transmitter: busy from the cycle after tx_en through the done cycle.
            if (e_en) begin
                tx_active = 1'b1;
                tx_start  = cyc;
                if (mode == 0) tx_len = 20;
                else if (mode == 1) tx_len = 5;
                else begin
                    r = $urandom_range(0, 9);
                    case (r)
                        0:       tx_len = 1000;
                        1:       tx_len = TO;
                        2:       tx_len = TO + 1;
                        default: tx_len = $urandom_range(1, 30);
                    endcase
                end
                busy_len = (tx_len > 70) ? 70 : tx_len;
            end
            if (tx_active) begin
                tx_done_v = (cyc == tx_start + tx_len);
                tx_busy_v = (cyc > tx_start) && (cyc <= tx_start + busy_len);
                if (cyc >= tx_start + busy_len) tx_active = 1'b0;
            end else if (mode >= 2) begin
                tx_busy_v = ($urandom_range(0, 9) == 0);
                tx_done_v = ($urandom_range(0, 11) == 0);
            end else begin
                tx_busy_v = 1'b0;
                tx_done_v = 1'b0;
            end

            // Reference model: expectations for the next cycle.
            n_ack = '0; n_done = '0; n_en = 1'b0; n_terr = 1'b0;
            if (rst_now) begin
                frame_open = 1'b0;
                free_at    = 0;
                last       = N - 1;
                e_gid      = '0;
                e_data     = '0;
            end else if (frame_open) begin
                if (cyc > launch_at) begin
                    if (tx_done_v) begin
                        n_done     = one_v << owner;
                        frame_open = 1'b0;
                        free_at    = cyc + 1 + gap;
                    end else if (cyc == launch_at + TO) begin
                        n_terr     = 1'b1;
                        frame_open = 1'b0;
                        free_at    = cyc + 1 + gap;
                    end
                end
            end else if (cyc >= free_at && req_v != '0 && !tx_busy_v) begin
                pick       = rr_next(last, req_v);
                n_en       = 1'b1;
                n_ack      = one_v << pick;
                e_gid      = 2'(pick);
                e_data     = bytes[pick];
                frame_open = 1'b1;
                launch_at  = cyc + 1;
                owner      = pick;
                last       = pick;
            end
            e_ack  = n_ack;
            e_done = n_done;
            e_en   = n_en;
            e_terr = n_terr;
            e_busy = frame_open || (cyc + 1 < free_at);
            if (rst_now) armed = 1'b1;
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) bytes[i] = '0;
        e_done = '0; e_terr = 1'b0; e_busy = 1'b0; e_gid = '0; e_data = '0;
        frame_open = 1'b0; free_at = 0; launch_at = 0; owner = 0; last = N - 1;
        run_phase(1'b0, 40,   0);   // single requester 0, byte A5, 20-cycle frame
        run_phase(1'b0, 200,  1);   // all four requesting continuously
        run_phase(1'b0, 4000, 2);   // random traffic, timeouts, strays, resets
        run_phase(1'b1, 3000, 3);   // same with a 3-cycle inter-frame gap
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_transmitter instance between NUM_REQ byte sources.
- Accepts requests and latches the winner's byte.
- Fires the transmitter's one-cycle tx_en trigger.
- Waits for tx_done, then reports completion to the owning requester.
- Enforces an optional inter-frame idle gap and a watchdog timeout.
- Sits between the APB register block / internal sources and the TX datapath.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_BITS, 8, byte width; must match the transmitter
GAP_CLKS, 0, idle PCLK cycles forced between frames (0 = no gap)
TIMEOUT_CLKS, 200000, max PCLK cycles waiting for tx_done (0 = watchdog disabled)

Ports:
PCLK  in  1  system clock
PRESET  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request; hold high with stable data until req_ack
req_data  in  NUM_REQ*DATA_BITS  packed bytes; requester i at [i*DATA_BITS +: DATA_BITS]
req_ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte accepted
req_done  out  NUM_REQ  one-hot, 1-cycle pulse: that requester's frame finished
tx_en  out  1  1-cycle trigger to transmitter
tx_data  out  DATA_BITS  byte to transmitter, stable from tx_en until next grant
tx_busy  in  1  transmitter busy
tx_done  in  1  transmitter done pulse
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
arb_busy  out  1  high in any state other than IDLE
timeout_err  out  1  1-cycle pulse when watchdog expires

Behaviour:
- Interface: one clock, PCLK. PRESET is synchronous and active-high, sampled on the PCLK rising edge.
- Reset values:
  - state=IDLE.
  - req_ack=0, req_done=0, tx_en=0, tx_data=0, grant_id=0, arb_busy=0, timeout_err=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Gap and timeout counters = 0.
- Reset mid-frame aborts immediately. No done is issued, no ack is repeated, and the transmitter is not reset by this block.
- All outputs are registered or are decoded purely from registered state (Moore). No combinational path from req or tx_* to outputs.
- States:
  - IDLE: if (|req) and tx_busy==0, select the first asserted req scanning last+1, last+2, … (mod NUM_REQ). Latch grant_id and the selected byte into tx_data. Next state is LAUNCH. If tx_busy==1, hold in IDLE without granting.
  - LAUNCH (exactly 1 cycle):
    - tx_en=1 and req_ack[grant_id]=1.
    - last<=grant_id.
    - Timeout counter cleared.
    - Next state is WAIT_DONE.
  - WAIT_DONE: counter increments each cycle.
    - tx_done=1: pulse req_done[grant_id] in the next cycle. Go to GAP if GAP_CLKS>0, else IDLE.
    - Counter reaches TIMEOUT_CLKS-1 with no tx_done (TIMEOUT_CLKS>0): pulse timeout_err next cycle, no req_done. Go to GAP/IDLE as above.
    - tx_done and expiry in the same cycle: tx_done wins, no timeout_err.
  - GAP: count GAP_CLKS cycles, then IDLE. Requests are not sampled in GAP.
- Latency:
  - req sampled high in IDLE at edge e → tx_en and req_ack during cycle e+1.
  - tx_done high at edge d → req_done during cycle d+1. Back in IDLE for cycle d+1 when GAP_CLKS=0.
  - Earliest next tx_en is cycle d+2.
- Request handling:
  - tx_done/tx_busy are ignored outside WAIT_DONE / IDLE respectively. A stray tx_done in IDLE/GAP produces nothing.
  - A req deasserted before grant is simply not served; no error.
  - A requester may re-request immediately after req_done. It loses to any other pending requester (round-robin fairness).
- Width: grant_id uses $clog2(NUM_REQ) bits. Timeout and gap counters use $clog2(max+1) bits, with no wrap past terminal count.

Test Plan:
1. NUM_REQ=4, GAP=0; req=4'b0001, byte 0xA5; model returns tx_done 20 cycles after tx_en → tx_en and req_ack=0001 one cycle after req; tx_data=0xA5; req_done=0001 one cycle after tx_done; arb_busy low afterwards.
2. req=4'b1111 held continuously (bytes 0x10,0x11,0x12,0x13) → grant order 0,1,2,3,0; each req_ack one-hot; exactly one tx_en per frame.
3. After grant to 2, req=4'b0101 → next grant is 0 (scan 3,0); then 2.
4. GAP_CLKS=3 → exactly 3 cycles between req_done and return to IDLE; next tx_en 5 cycles after tx_done.
5. TIMEOUT_CLKS=50, model never asserts tx_done → timeout_err pulse 51 cycles after tx_en, no req_done, next requester is served; tx_done coinciding with expiry → req_done only.
6. Assert PRESET in WAIT_DONE → next cycle all outputs zero, last=3; with tx_busy=1 held, req=0001 → no tx_en until tx_busy falls.
